result_transmitter: RTL and testbench
=====================================

Name: result_transmitter

Overview:
- AXI4-Stream master that returns computed results (output feature map / partial sums) from the output buffer SRAM to the DMA.
- Transmit-side counterpart of the input distributor.
- On a start pulse from the controller, it reads a programmed number of 16-bit words from the output buffer at addresses 0..length-1 and emits one word per 32-bit beat.
- It asserts TLAST on the final beat and pulses done on completion.

Parameters:
- ADDR_W, 10, output buffer address width; max transfer is 2^ADDR_W words.
- DATA_W, 16, width of one result word; must be ≤ 32.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from controller; begins a transfer.
- length  in  ADDR_W+1  number of words to send; sampled when start is accepted.
- rd_en  out  1  output buffer read enable.
- rd_addr  out  ADDR_W  output buffer read address.
- rd_data  in  DATA_W  output buffer read data; valid exactly 1 cycle after rd_en.
- M_AXIS_TDATA  out  32  {zero-extend, rd_data word} in bits [DATA_W-1:0].
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TLAST  out  1  marks final beat.
- M_AXIS_TREADY  in  1  slave ready.
- busy  out  1  high from start acceptance until the last beat transfers.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - TVALID=0, TLAST=0, TDATA=0, rd_en=0, rd_addr=0, busy=0, done=0.
  - FIFO, counters and FSM are cleared to IDLE.
- FSM states:
  - IDLE: wait for start; busy=0.
  - STREAM: issue reads and drain the FIFO.
  - FINISH: one cycle; done=1; return to IDLE.
- Start handling:
  - start is accepted only in IDLE; start in STREAM or FINISH is ignored.
  - On acceptance, latch length and clear issue_cnt, beat_cnt and rd_addr to 0.
  - If length≠0, go to STREAM and set busy=1.
  - If length==0, go directly to FINISH: no reads, no beats, done pulses the cycle after start is sampled.
- Read issue:
  - rd_en is combinational in STREAM.
  - rd_en=1 when issue_cnt<length AND (fifo_cnt + inflight − pop) < 2.
  - pop = TVALID & TREADY this cycle; inflight = rd_en of the previous cycle.
  - Each issued read increments rd_addr and issue_cnt.
  - rd_addr holds its value when rd_en=0.
- Capture:
  - The registered copy of rd_en pushes rd_data into a 2-entry FIFO on the next edge.
  - The FIFO must never overflow; the bench flags an assertion if it does.
- Output:
  - TVALID = FIFO non-empty.
  - TDATA = FIFO head, zero-extended.
  - TLAST = TVALID AND (beat_cnt == length−1).
  - Once TVALID=1, TDATA and TLAST stay stable until TVALID&TREADY (AXIS rule).
  - TVALID never depends on TREADY.
- Transfer:
  - On TVALID&TREADY: pop the FIFO and increment beat_cnt.
  - Simultaneous push and pop in the same cycle keeps fifo_cnt unchanged.
- Completion:
  - Transfer of the TLAST beat moves the FSM to FINISH and drops busy the following cycle.
  - done=1 for exactly one cycle in FINISH.
  - The FIFO is empty and TVALID=0 in FINISH.
- Latency:
  - start sampled at edge k.
  - First rd_en during cycle k+1.
  - First TVALID during cycle k+2.
- Throughput: with TREADY held high, one beat per cycle with no bubbles; length N completes in N+2 cycles after start, plus the FINISH cycle.
- Backpressure: with TREADY low, at most 2 words are buffered and rd_en stays low until space frees.
- Maximum length: length = 2^ADDR_W is legal; rd_addr wraps to 0 after the final read, with no further reads issued.
- Reset mid-transfer: transfer is abandoned, outputs return to reset values immediately, and no done pulse is generated.
- TDATA when TVALID=0: holds its last value; no X after reset.

Test Plan:
1. Buffer[0..3] = 0x0011, 0x0022, 0x0033, 0x0044; length=4; start at k; TREADY=1 →
   - rd_en in cycles k+1..k+4 with addresses 0..3.
   - TVALID in cycles k+2..k+5; TDATA = 0x00000011 … 0x00000044.
   - TLAST only in k+5; done in k+6; busy low from k+7.
2. Same data; TREADY toggles 1,0,0,1,… →
   - Each beat is held stable while TREADY=0; at most 2 outstanding reads.
   - Beat order 0x11, 0x22, 0x33, 0x44 is preserved; TLAST stays on 0x44 only.
3. length=0, start →
   - No rd_en, no TVALID; done one cycle after start; busy stays 0.
4. length=1, buffer[0]=0xBEEF, TREADY=1 →
   - A single beat TDATA=0x0000BEEF with TVALID=TLAST=1; done the next cycle.
5. length=8, second start pulse at beat 3 with length=2 →
   - The second start is ignored; exactly 8 beats are sent; TLAST on beat 8; a single done.
6. length=8; reset_n low for 1 cycle after beat 4 →
   - TVALID, rd_en and busy are 0 immediately; no done.
   - A subsequent start with length=2 sends addresses 0,1 correctly.

Source files
------------

// File: rtl/result_transmitter.sv
// AXI4-Stream master that streams result words from the output buffer SRAM to the DMA.
// A 2-entry skid FIFO with read-data bypass keeps one beat per cycle while honouring backpressure.
module result_transmitter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W:0]   length,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [31:0]       M_AXIS_TDATA,
   output logic              M_AXIS_TVALID,
   output logic              M_AXIS_TLAST,
   input  logic              M_AXIS_TREADY,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FINISH
   } state_t;

   state_t            state;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   issue_cnt;
   logic [ADDR_W:0]   beat_cnt;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        fifo_cnt;
   logic              inflight;
   logic [31:0]       tdata_hold;

   logic              fifo_empty;
   logic              pop;
   logic              store;
   logic              drop;
   logic              last_beat;
   logic [2:0]        occupancy;
   logic [DATA_W-1:0] head;
   logic [31:0]       head_ext;

   // The word arriving from the SRAM is presented directly when the FIFO is empty,
   // so it counts as buffered data even before it is written into the FIFO.
   assign fifo_empty    = (fifo_cnt == 2'd0);
   assign head          = fifo_empty ? rd_data : fifo_mem[rd_ptr];
   assign head_ext      = 32'(head);
   assign M_AXIS_TVALID = !fifo_empty || inflight;
   assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
   assign M_AXIS_TDATA  = M_AXIS_TVALID ? head_ext : tdata_hold;
   assign last_beat     = (beat_cnt == len_q - (ADDR_W + 1)'(1));
   assign M_AXIS_TLAST  = M_AXIS_TVALID && last_beat;
   assign occupancy     = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
   assign rd_en         = (state == STREAM) && (issue_cnt < len_q) && (occupancy < 3'd2);
   assign store         = inflight && !(fifo_empty && pop);
   assign drop          = pop && !fifo_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
         inflight    <= 1'b0;
         tdata_hold  <= '0;
      end else begin
         inflight <= rd_en;
         if (store) begin
            fifo_mem[wr_ptr] <= rd_data;
            wr_ptr           <= ~wr_ptr;
         end
         if (drop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt <= fifo_cnt + 2'(store) - 2'(drop);
         if (M_AXIS_TVALID) begin
            tdata_hold <= head_ext;
         end
      end
   end

   // A zero-length request skips STREAM entirely and never raises busy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         len_q     <= '0;
         issue_cnt <= '0;
         beat_cnt  <= '0;
         rd_addr   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  len_q     <= length;
                  issue_cnt <= '0;
                  beat_cnt  <= '0;
                  rd_addr   <= '0;
                  if (length != '0) begin
                     state <= STREAM;
                     busy  <= 1'b1;
                  end else begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (rd_en) begin
                  rd_addr   <= rd_addr + 1'b1;
                  issue_cnt <= issue_cnt + 1'b1;
               end
               if (pop) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_transmitter.sv
// Self-checking bench for result_transmitter: SRAM model, per-cycle recorder and
// scenario tasks comparing the recorded stream against the buffer contents.
module tb_result_transmitter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [ADDR_W:0]   length;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data = '0;
   logic [31:0]       tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] sram [DEPTH];

   int compared   = 0;
   int mismatched = 0;

   int          q_addr[$];
   int          q_rdcyc[$];
   logic [31:0] q_data[$];
   logic        q_last[$];
   int          q_beatcyc[$];
   int done_cnt, done_cyc, last_busy, valid_cnt, tlast_cnt, stab_err, max_out;
   int rdy_mode, restart_beat, stop_beat, restarted;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) rd_data <= sram[rd_addr];
   end

   result_transmitter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .length        (length),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .M_AXIS_TDATA  (tdata),
      .M_AXIS_TVALID (tvalid),
      .M_AXIS_TLAST  (tlast),
      .M_AXIS_TREADY (tready),
      .busy          (busy),
      .done          (done)
   );

   function automatic logic ready_for(int c);
      case (rdy_mode)
         0:       return 1'b1;
         1:       return (c % 3) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic clear_record();
      q_addr.delete(); q_rdcyc.delete(); q_data.delete(); q_last.delete(); q_beatcyc.delete();
      done_cnt = 0; done_cyc = -1; last_busy = -1; valid_cnt = 0; tlast_cnt = 0;
      stab_err = 0; max_out = 0; restart_beat = 0; stop_beat = 0; restarted = 0;
   endtask

   task automatic launch(int len);
      @(posedge clk); #1;
      start  = 1'b1;
      length = (ADDR_W + 1)'(len);
      tready = ready_for(0);
   endtask

   // Cycle 0 is the cycle in which start is high; everything is sampled on the falling edge.
   task automatic collect(int ncyc);
      int          outst = 0;
      logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [31:0] pd = '0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (rd_en) begin q_addr.push_back(int'(rd_addr)); q_rdcyc.push_back(c); outst++; end
         if (pv && !pr && (!tvalid || tdata !== pd || tlast !== pl)) stab_err++;
         if (tvalid) valid_cnt++;
         if (tvalid && tlast) tlast_cnt++;
         if (tvalid && tready) begin
            q_data.push_back(tdata); q_last.push_back(tlast); q_beatcyc.push_back(c); outst--;
         end
         if (outst > max_out) max_out = outst;
         if (busy) last_busy = c;
         if (done) begin done_cnt++; done_cyc = c; end
         pv = tvalid; pr = tready; pd = tdata; pl = tlast;
         if (stop_beat > 0 && q_data.size() == stop_beat) break;
         @(posedge clk); #1;
         start = 1'b0;
         if (restart_beat > 0 && q_data.size() == restart_beat && restarted == 0) begin
            start = 1'b1; length = (ADDR_W + 1)'(2); restarted = 1;
         end
         tready = ready_for(c + 1);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; length = '0; tready = 1'b0;
      #2;
      compared++; if (tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tvalid: got %b want 0", tvalid); end
      compared++; if (tlast !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tlast: got %b want 0", tlast); end
      compared++; if (tdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_tdata: got %h want 0", tdata); end
      compared++; if (rd_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_en: got %b want 0", rd_en); end
      compared++; if (rd_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_rd_addr: got %0d want 0", rd_addr); end
      compared++; if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy_done: got %b%b want 00", busy, done); end
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_basic();
      int bad = 0;
      sram[0] = 16'h0011; sram[1] = 16'h0022; sram[2] = 16'h0033; sram[3] = 16'h0044;
      clear_record(); rdy_mode = 0;
      launch(4); collect(12);
      for (int i = 0; i < 4; i++) begin
         if (i >= q_addr.size() || q_addr[i] != i || q_rdcyc[i] != i + 1) bad++;
         if (i >= q_data.size() || q_data[i] !== 32'(sram[i]) || q_beatcyc[i] != i + 2 || q_last[i] !== (i == 3)) bad++;
      end
      compared++; if (bad != 0 || q_addr.size() != 4 || q_data.size() != 4) begin mismatched++;
         $display("[TB] FAIL basic_stream: %0d bad slots, reads %0d beats %0d, want 0 bad 4 reads 4 beats", bad, q_addr.size(), q_data.size()); end
      compared++; if (valid_cnt != 4 || tlast_cnt != 1) begin mismatched++;
         $display("[TB] FAIL basic_valid: valid cycles %0d tlast cycles %0d, want 4 and 1", valid_cnt, tlast_cnt); end
      compared++; if (done_cnt != 1 || done_cyc != 6) begin mismatched++;
         $display("[TB] FAIL basic_done: count %0d cycle %0d, want 1 at 6", done_cnt, done_cyc); end
      compared++; if (last_busy != 6) begin mismatched++;
         $display("[TB] FAIL basic_busy: last busy cycle %0d, want 6", last_busy); end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      clear_record(); rdy_mode = 1;
      launch(4); collect(30);
      for (int i = 0; i < q_data.size() && i < 4; i++)
         if (q_data[i] !== 32'(sram[i]) || q_last[i] !== (i == 3) || q_addr[i] != i) bad++;
      compared++; if (bad != 0 || q_data.size() != 4 || q_addr.size() != 4) begin mismatched++;
         $display("[TB] FAIL bp_order: %0d bad, beats %0d reads %0d, want 0 bad 4 beats 4 reads", bad, q_data.size(), q_addr.size()); end
      compared++; if (stab_err != 0) begin mismatched++; $display("[TB] FAIL bp_stable: %0d violations, want 0", stab_err); end
      compared++; if (max_out > 2) begin mismatched++; $display("[TB] FAIL bp_outstanding: peak %0d, want <= 2", max_out); end
      compared++; if (tlast_cnt < 1 || done_cnt != 1) begin mismatched++;
         $display("[TB] FAIL bp_done: tlast cycles %0d done %0d, want >=1 and 1", tlast_cnt, done_cnt); end
   endtask

   task automatic test_zero_length();
      clear_record(); rdy_mode = 0;
      launch(0); collect(6);
      compared++; if (q_addr.size() != 0 || valid_cnt != 0) begin mismatched++;
         $display("[TB] FAIL zero_activity: reads %0d valid cycles %0d, want 0 0", q_addr.size(), valid_cnt); end
      compared++; if (done_cnt != 1 || done_cyc != 1) begin mismatched++;
         $display("[TB] FAIL zero_done: count %0d cycle %0d, want 1 at 1", done_cnt, done_cyc); end
      compared++; if (last_busy != -1) begin mismatched++; $display("[TB] FAIL zero_busy: busy seen at %0d, want never", last_busy); end
   endtask

   task automatic test_single();
      sram[0] = 16'hBEEF;
      clear_record(); rdy_mode = 0;
      launch(1); collect(6);
      compared++; if (q_data.size() != 1 || q_data[0] !== 32'h0000BEEF || q_last[0] !== 1'b1) begin mismatched++;
         $display("[TB] FAIL single_beat: beats %0d first %h, want 1 beat 0000beef with tlast", q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx); end
      compared++; if (done_cnt != 1 || done_cyc != 3) begin mismatched++;
         $display("[TB] FAIL single_done: count %0d cycle %0d, want 1 at 3", done_cnt, done_cyc); end
   endtask

   task automatic test_ignored_restart();
      int bad = 0;
      for (int i = 0; i < 8; i++) sram[i] = DATA_W'($urandom);
      clear_record(); rdy_mode = 2; restart_beat = 3;
      launch(8); collect(80);
      for (int i = 0; i < q_data.size() && i < 8; i++)
         if (q_data[i] !== 32'(sram[i]) || q_last[i] !== (i == 7)) bad++;
      compared++; if (bad != 0 || q_data.size() != 8 || restarted != 1) begin mismatched++;
         $display("[TB] FAIL restart_beats: %0d bad, beats %0d, restart issued %0d, want 0 bad 8 beats 1", bad, q_data.size(), restarted); end
      compared++; if (q_addr.size() != 8 || done_cnt != 1) begin mismatched++;
         $display("[TB] FAIL restart_done: reads %0d done %0d, want 8 and 1", q_addr.size(), done_cnt); end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      for (int i = 0; i < 8; i++) sram[i] = DATA_W'($urandom);
      clear_record(); rdy_mode = 0; stop_beat = 4;
      launch(8); collect(20);
      compared++; if (q_data.size() != 4) begin mismatched++; $display("[TB] FAIL mid_prefix: beats %0d, want 4", q_data.size()); end
      @(posedge clk); #1; reset_n = 1'b0; #1;
      compared++; if (tvalid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || tdata !== 32'h0) begin mismatched++;
         $display("[TB] FAIL mid_reset_outputs: tvalid %b rd_en %b busy %b tdata %h, want 0 0 0 0", tvalid, rd_en, busy, tdata); end
      @(posedge clk); #1; reset_n = 1'b1; start = 1'b0;
      clear_record(); collect(6);
      compared++; if (done_cnt != 0 || valid_cnt != 0) begin mismatched++;
         $display("[TB] FAIL mid_no_done: done %0d valid cycles %0d, want 0 0", done_cnt, valid_cnt); end
      sram[0] = DATA_W'($urandom); sram[1] = DATA_W'($urandom);
      clear_record(); rdy_mode = 0;
      launch(2); collect(8);
      for (int i = 0; i < 2; i++)
         if (i >= q_data.size() || i >= q_addr.size() || q_addr[i] != i || q_data[i] !== 32'(sram[i]) || q_last[i] !== (i == 1)) bad++;
      compared++; if (bad != 0 || q_addr.size() != 2 || done_cnt != 1) begin mismatched++;
         $display("[TB] FAIL mid_restart: %0d bad, reads %0d done %0d, want 0 bad 2 reads 1 done", bad, q_addr.size(), done_cnt); end
   endtask

   task automatic test_random();
      for (int t = 0; t < 4; t++) begin
         int len = $urandom_range(1, 40);
         int bad = 0;
         for (int i = 0; i < len; i++) sram[i] = DATA_W'($urandom);
         clear_record(); rdy_mode = 2;
         launch(len); collect(len * 8 + 40);
         for (int i = 0; i < q_data.size() && i < len; i++)
            if (q_data[i] !== 32'(sram[i]) || q_last[i] !== (i == len - 1) || q_addr[i] != i) bad++;
         compared++; if (bad != 0 || q_data.size() != len || q_addr.size() != len) begin mismatched++;
            $display("[TB] FAIL random_%0d: %0d bad, beats %0d reads %0d, want 0 bad %0d", t, bad, q_data.size(), q_addr.size(), len); end
         compared++; if (stab_err != 0 || max_out > 2 || done_cnt != 1) begin mismatched++;
            $display("[TB] FAIL random_rules_%0d: stab %0d peak %0d done %0d, want 0 <=2 1", t, stab_err, max_out, done_cnt); end
      end
   endtask

   task automatic test_max_length();
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) sram[i] = DATA_W'($urandom);
      clear_record(); rdy_mode = 0;
      launch(DEPTH); collect(DEPTH + 10);
      for (int i = 0; i < q_data.size() && i < DEPTH; i++)
         if (q_data[i] !== 32'(sram[i]) || q_addr[i] != i) bad++;
      compared++; if (bad != 0 || q_data.size() != DEPTH || q_addr.size() != DEPTH) begin mismatched++;
         $display("[TB] FAIL max_stream: %0d bad, beats %0d reads %0d, want 0 bad %0d", bad, q_data.size(), q_addr.size(), DEPTH); end
      compared++; if (tlast_cnt != 1 || done_cnt != 1 || done_cyc != DEPTH + 2) begin mismatched++;
         $display("[TB] FAIL max_done: tlast %0d done %0d at %0d, want 1 1 at %0d", tlast_cnt, done_cnt, done_cyc, DEPTH + 2); end
      compared++; if (rd_addr !== '0) begin mismatched++; $display("[TB] FAIL max_wrap: rd_addr %0d, want 0", rd_addr); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_length();
      test_single();
      test_ignored_restart();
      test_reset_mid();
      test_random();
      test_max_length();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
